// File: rtl/viterbi_pkg.sv
// Shared widths and trellis state indices for the Viterbi decoder datapath.
// Used by the ACS-stage survivor selector and its compare tree.
package viterbi_pkg;

  localparam int PATH_W   = 8;
  localparam int METRIC_W = 4;
  localparam int PTR_W    = 3;

  localparam int NUM_STATES = 4;

  typedef enum logic [1:0] {
    S00 = 2'd0,
    S01 = 2'd1,
    S10 = 2'd2,
    S11 = 2'd3
  } state_idx_t;

endpackage

// File: rtl/metric_min2.sv
// Two-way compare of (metric, path, state index) tuples.
// The left operand wins on equal metrics, so a tree of these favours lower state indices.
module metric_min2
  import viterbi_pkg::*;
#(
  parameter int P_W = PATH_W,
  parameter int M_W = METRIC_W
) (
  input  logic [M_W-1:0] metric_a,
  input  logic [P_W-1:0] path_a,
  input  state_idx_t     idx_a,
  input  logic [M_W-1:0] metric_b,
  input  logic [P_W-1:0] path_b,
  input  state_idx_t     idx_b,
  output logic [M_W-1:0] metric_y,
  output logic [P_W-1:0] path_y,
  output state_idx_t     idx_y
);

  logic take_b;

  // Strict less-than keeps the left operand on a tie.
  assign take_b = (metric_b < metric_a);

  always_comb begin
    metric_y = metric_a;
    path_y   = path_a;
    idx_y    = idx_a;
    if (take_b) begin
      metric_y = metric_b;
      path_y   = path_b;
      idx_y    = idx_b;
    end
  end

endmodule

// File: rtl/selector.sv
// Survivor-path selector: registers the path of the minimum-metric trellis state.
// Ties resolve toward the lowest state index through a left-biased 2-level tree.
module selector
  import viterbi_pkg::*;
#(
  parameter int P_W   = PATH_W,
  parameter int M_W   = METRIC_W,
  parameter int PT_W  = PTR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [P_W-1:0]  updated_selected_branch_at_00,
  input  logic [P_W-1:0]  updated_selected_branch_at_01,
  input  logic [P_W-1:0]  updated_selected_branch_at_10,
  input  logic [P_W-1:0]  updated_selected_branch_at_11,
  input  logic [M_W-1:0]  new_branch_metric_00,
  input  logic [M_W-1:0]  new_branch_metric_01,
  input  logic [M_W-1:0]  new_branch_metric_10,
  input  logic [M_W-1:0]  new_branch_metric_11,
  input  logic [PT_W-1:0] write_pointer_in,
  input  logic            valid_in,
  output logic [P_W-1:0]  out
);

  logic [P_W-1:0] path_arr   [NUM_STATES];
  logic [M_W-1:0] metric_arr [NUM_STATES];

  assign path_arr[0]   = updated_selected_branch_at_00;
  assign path_arr[1]   = updated_selected_branch_at_01;
  assign path_arr[2]   = updated_selected_branch_at_10;
  assign path_arr[3]   = updated_selected_branch_at_11;
  assign metric_arr[0] = new_branch_metric_00;
  assign metric_arr[1] = new_branch_metric_01;
  assign metric_arr[2] = new_branch_metric_10;
  assign metric_arr[3] = new_branch_metric_11;

  // First tree level: stage A = min(00,01), stage B = min(10,11).
  logic [M_W-1:0] lvl1_metric [2];
  logic [P_W-1:0] lvl1_path   [2];
  state_idx_t     lvl1_idx    [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lvl1
      localparam state_idx_t IDX_L = state_idx_t'(2'(2 * gi));
      localparam state_idx_t IDX_R = state_idx_t'(2'(2 * gi + 1));

      metric_min2 #(
        .P_W (P_W),
        .M_W (M_W)
      ) u_min (
        .metric_a (metric_arr[2*gi]),
        .path_a   (path_arr[2*gi]),
        .idx_a    (IDX_L),
        .metric_b (metric_arr[2*gi+1]),
        .path_b   (path_arr[2*gi+1]),
        .idx_b    (IDX_R),
        .metric_y (lvl1_metric[gi]),
        .path_y   (lvl1_path[gi]),
        .idx_y    (lvl1_idx[gi])
      );
    end
  endgenerate

  logic [M_W-1:0] best_metric;
  logic [P_W-1:0] best_path;
  state_idx_t     best_idx;

  metric_min2 #(
    .P_W (P_W),
    .M_W (M_W)
  ) u_min_final (
    .metric_a (lvl1_metric[0]),
    .path_a   (lvl1_path[0]),
    .idx_a    (lvl1_idx[0]),
    .metric_b (lvl1_metric[1]),
    .path_b   (lvl1_path[1]),
    .idx_b    (lvl1_idx[1]),
    .metric_y (best_metric),
    .path_y   (best_path),
    .idx_y    (best_idx)
  );

  logic [P_W-1:0]  out_reg;
  logic [PT_W-1:0] wr_ptr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_reg    <= '0;
      wr_ptr_reg <= '0;
    end else if (valid_in) begin
      out_reg    <= best_path;
      wr_ptr_reg <= write_pointer_in;
    end
  end

  assign out = out_reg;

  // The pointer, winning metric and index are held for the traceback stage, which is not attached yet.
  logic unused_sink;
  assign unused_sink = ^{wr_ptr_reg, best_metric, best_idx};

endmodule

// File: tb/tb_selector.sv
// Self-checking bench for selector: directed cases from the test plan plus randomized
// traffic compared every cycle against an argmin-with-first-index reference model.
module tb_selector;

  localparam int PW = 8;
  localparam int MW = 4;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PW-1:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0;
  logic [MW-1:0] m0 = '0, m1 = '0, m2 = '0, m3 = '0;
  logic [TW-1:0] wp = '0;
  logic          valid_in = 1'b0;
  logic [PW-1:0] out;

  int checks = 0;
  int fails  = 0;
  logic cmp_en = 1'b0;
  logic [PW-1:0] exp_out = '0;

  selector dut (
    .clk                           (clk),
    .rst                           (rst),
    .updated_selected_branch_at_00 (p0),
    .updated_selected_branch_at_01 (p1),
    .updated_selected_branch_at_10 (p2),
    .updated_selected_branch_at_11 (p3),
    .new_branch_metric_00          (m0),
    .new_branch_metric_01          (m1),
    .new_branch_metric_10          (m2),
    .new_branch_metric_11          (m3),
    .write_pointer_in              (wp),
    .valid_in                      (valid_in),
    .out                           (out)
  );

  always #5 clk = ~clk;

  // Reference: scan states in order, replacing only on a strictly smaller metric.
  function automatic logic [PW-1:0] ref_best(input logic [MW-1:0] ma, mb, mc, md,
                                             input logic [PW-1:0] pa, pb, pc, pd);
    int unsigned mets [4];
    logic [PW-1:0] paths [4];
    int best;
    mets[0] = ma; mets[1] = mb; mets[2] = mc; mets[3] = md;
    paths[0] = pa; paths[1] = pb; paths[2] = pc; paths[3] = pd;
    best = 0;
    for (int i = 1; i < 4; i++)
      if (mets[i] < mets[best]) best = i;
    return paths[best];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst)
      exp_out = '0;
    else if (valid_in)
      exp_out = ref_best(m0, m1, m2, m3, p0, p1, p2, p3);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (out !== exp_out) begin
        fails++;
        $display("FAIL model_cmp t=%0t out=%h expected=%h", $time, out, exp_out);
      end
    end
  end

  task automatic check_lit(input string name, input logic [PW-1:0] want);
    checks++;
    if (out !== want) begin
      fails++;
      $display("FAIL %s out=%h expected=%h", name, out, want);
    end else begin
      $display("ok   %s out=%h", name, out);
    end
  endtask

  task automatic drive(input logic v, input logic [MW-1:0] a, b, c, d,
                       input logic [PW-1:0] w, x, y, z);
    valid_in = v;
    m0 = a; m1 = b; m2 = c; m3 = d;
    p0 = w; p1 = x; p2 = y; p3 = z;
    wp = TW'($urandom);
  endtask

  task automatic step_check(input string name, input logic [PW-1:0] want);
    @(posedge clk);
    #1;
    check_lit(name, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset asserted with arbitrary inputs, before any clock edge.
    drive(1'b1, 4'h3, 4'h1, 4'h2, 4'h0, 8'h11, 8'h22, 8'h33, 8'h44);
    #2;
    check_lit("reset_no_clock", 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b0, 4'h3, 4'h1, 4'h2, 4'h0, 8'h11, 8'h22, 8'h33, 8'h44);
    cmp_en = 1'b1;
    step_check("release_invalid", 8'h00);

    drive(1'b1, 4'h1, 4'h5, 4'h7, 4'h9, 8'hA0, 8'hB0, 8'hC0, 8'hD0);
    step_check("min_s00", 8'hA0);
    drive(1'b1, 4'h8, 4'h2, 4'h6, 4'h7, 8'hA1, 8'hB1, 8'hC1, 8'hD1);
    step_check("min_s01", 8'hB1);
    drive(1'b1, 4'h9, 4'h8, 4'h3, 4'h7, 8'hA2, 8'hB2, 8'hC2, 8'hD2);
    step_check("min_s10", 8'hC2);
    drive(1'b1, 4'h9, 4'h8, 4'h7, 4'h4, 8'hA3, 8'hB3, 8'hC3, 8'hD3);
    step_check("min_s11", 8'hD3);
    drive(1'b1, 4'h5, 4'h5, 4'h5, 4'h5, 8'hA4, 8'hB4, 8'hC4, 8'hD4);
    step_check("tie_all", 8'hA4);
    drive(1'b1, 4'h9, 4'h5, 4'h5, 4'h9, 8'hA8, 8'hB8, 8'hC8, 8'hD8);
    step_check("tie_mid", 8'hB8);
    drive(1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 8'hA5, 8'hB5, 8'hC5, 8'hD5);
    step_check("zero_vs_f", 8'hD5);

    drive(1'b0, 4'h1, 4'h2, 4'h3, 4'h4, 8'hA6, 8'hB6, 8'hC6, 8'hD6);
    for (int i = 0; i < 3; i++) step_check($sformatf("hold_%0d", i), 8'hD5);

    // Reset asserted between edges with valid_in=1 pending.
    drive(1'b1, 4'h4, 4'h3, 4'h2, 4'h1, 8'hA7, 8'hB7, 8'hC7, 8'hD7);
    #2;
    rst = 1'b0;
    #1;
    check_lit("async_reset_immediate", 8'h00);
    step_check("reset_over_valid", 8'h00);
    rst = 1'b1;
    step_check("post_reset_valid", 8'hD7);

    // Randomized back-to-back traffic with biased ties and occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      logic [MW-1:0] r [4];
      for (int k = 0; k < 4; k++)
        r[k] = ($urandom_range(0, 1) == 0) ? MW'($urandom_range(0, 2)) : MW'($urandom);
      drive(($urandom_range(0, 3) != 0), r[0], r[1], r[2], r[3],
            PW'($urandom), PW'($urandom), PW'($urandom), PW'($urandom));
      rst = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
